// File: rtl/risc_v_string_uart_tx.sv
// rtl/risc_v_string_uart_tx.sv - 8N1 UART transmitter for the NUL-terminated string in x7/x8/x9
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-high reset
//   start      : request a transmission, sampled only while idle
//   words      : packed string words, word i at [32*i+31:32*i], big-endian bytes
//   tx         : UART serial out, idles high
//   busy       : high from the start-accept edge until the done edge
//   done       : one-cycle pulse at the end of a transmission
//   byte_count : bytes sent in the last/current transmission
module risc_v_string_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int NUM_WORDS    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [32*NUM_WORDS-1:0]            words,
    output logic                               tx,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(4*NUM_WORDS+1)-1:0]   byte_count
);

    localparam int NUM_BYTES = 4 * NUM_WORDS;
    localparam int CW        = $clog2(NUM_BYTES + 1);
    localparam int BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [32*NUM_WORDS-1:0]  buf_q, buf_d;
    logic [CW-1:0]            idx_q, idx_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BW-1:0]            baud_q, baud_d;
    logic [2:0]               bit_q, bit_d;
    logic [7:0]               shift_q, shift_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [7:0]               byte_arr [NUM_BYTES];
    logic [7:0]               sel_byte;
    logic                     baud_end;

    // Byte 0 is the most significant byte of word0 (x7), and so on.
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_bytes
        assign byte_arr[i] = buf_q[32*(i/4) + 8*(3 - i%4) +: 8];
    end

    // Index past the end reads as NUL, so "string full" and "NUL found" share one test.
    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == CW'(i)) begin
                sel_byte = byte_arr[i];
            end
        end
    end

    assign baud_end = (baud_q == BAUD_LAST);

    // tx, busy and done are registered, so tx follows the state by one cycle:
    // start accepted at edge k gives LOAD, START from k+1, tx low at k+2.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    buf_d   = words;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                baud_d = '0;
                bit_d  = '0;
                if (sel_byte == 8'h00) begin
                    state_d = DONE;
                end else begin
                    shift_d = sel_byte;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    cnt_d   = cnt_q + CW'(1);
                    idx_d   = idx_q + CW'(1);
                    state_d = LOAD;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_risc_v_string_uart_tx.sv
// tb/tb_risc_v_string_uart_tx.sv - self-checking bench for risc_v_string_uart_tx
module tb_risc_v_string_uart_tx;

    localparam int CPB    = 4;
    localparam int NW     = 3;
    localparam int NB     = 4 * NW;
    localparam int FRAME  = 10 * CPB + 1;
    localparam int CW     = $clog2(NB + 1);
    localparam logic [95:0] HELLO = {32'h726C6421, 32'h6F20576F, 32'h48656C6C};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [95:0]   words;
    logic          tx;
    logic          busy;
    logic          done;
    logic [CW-1:0] byte_count;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int rx_err = 0;
    logic [7:0] rx_q[$];

    risc_v_string_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_WORDS   (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .words     (words),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // Independent UART receiver: mid-bit sampling, frames pushed to rx_q.
    initial begin
        logic [7:0] rxb;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (tx !== 1'b0) rx_err++;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rxb[b] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) rx_err++;
                rx_q.push_back(rxb);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_err   = 0;
        done_cnt = 0;
    endtask

    // Returns at the negedge just after the accepting posedge.
    task automatic pulse_start(input logic [95:0] w);
        @(negedge clk);
        words = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_check(input logic [95:0] w, input string tag);
        logic [7:0] exp_q[$];
        logic [31:0] w32;
        logic [7:0] b;
        logic seen;
        for (int i = 0; i < NB; i++) begin
            w32 = w[32*(i/4) +: 32];
            b   = 8'((w32 >> (24 - 8*(i % 4))) & 32'hFF);
            if (b == 8'h00) break;
            exp_q.push_back(b);
        end
        seen = 1'b0;
        for (int c = 0; c < (NB + 1) * FRAME + 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
        @(negedge clk);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
        check({tag, "_busy_low"}, 64'(busy), 64'(0));
        check({tag, "_tx_idle"}, 64'(tx), 64'(1));
        check({tag, "_byte_count"}, 64'(byte_count), 64'(exp_q.size()));
        check({tag, "_frame_err"}, 64'(rx_err), 64'(0));
        check({tag, "_rx_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
        end
    endtask

    function automatic logic [95:0] rand_string(input int len);
        logic [95:0] w;
        logic [7:0]  b;
        for (int i = 0; i < NB; i++) begin
            if (i < len)       b = 8'($urandom_range(1, 255));
            else if (i == len) b = 8'h00;
            else               b = 8'($urandom);
            w[32*(i/4) + 8*(3 - i%4) +: 8] = b;
        end
        return w;
    endfunction

    initial begin
        logic [42:0]  cap;
        logic [42:0]  expv;
        logic [7:0]   h;
        logic [95:0]  w;

        rst   = 1'b1;
        start = 1'b0;
        words = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 64'(tx), 64'(1));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_byte_count", 64'(byte_count), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Hello World!, with bit-exact first frame and start latency.
        clear_rx();
        pulse_start(HELLO);
        check("hello_busy_after_accept", 64'(busy), 64'(1));
        cap[0] = tx;
        for (int n = 1; n < 43; n++) begin
            @(negedge clk);
            cap[n] = tx;
        end
        h = 8'h48;
        expv[0] = 1'b1;
        expv[1] = 1'b1;
        for (int j = 0; j < 41; j++) begin
            if (j < CPB)            expv[2+j] = 1'b0;
            else if (j < 9 * CPB)   expv[2+j] = h[(j - CPB) / CPB];
            else                    expv[2+j] = 1'b1;
        end
        check("hello_first_frame_bits", 64'(cap), 64'(expv));
        finish_check(HELLO, "hello");

        // Bye, then NUL word.
        clear_rx();
        pulse_start({32'($urandom), 32'h00000000, 32'h4279652C});
        finish_check({32'h0, 32'h00000000, 32'h4279652C}, "bye");

        // Leading NUL: no frames, done two cycles after accept.
        clear_rx();
        pulse_start({32'($urandom), 32'($urandom), 32'h00414243});
        check("nul_busy_n0", 64'(busy), 64'(1));
        check("nul_done_n0", 64'(done), 64'(0));
        check("nul_tx_n0", 64'(tx), 64'(1));
        @(negedge clk);
        check("nul_done_n1", 64'(done), 64'(0));
        check("nul_tx_n1", 64'(tx), 64'(1));
        @(negedge clk);
        check("nul_done_n2", 64'(done), 64'(1));
        check("nul_busy_n2", 64'(busy), 64'(0));
        check("nul_byte_count", 64'(byte_count), 64'(0));
        repeat (2 * FRAME) @(negedge clk);
        check("nul_no_frames", 64'(rx_q.size()), 64'(0));
        check("nul_done_pulses", 64'(done_cnt), 64'(1));

        // Restart during frame 3 and words changed mid-transmission.
        clear_rx();
        pulse_start(HELLO);
        repeat (2 * FRAME + 10) @(negedge clk);
        start = 1'b1;
        words = {32'($urandom), 32'($urandom), 32'($urandom)};
        @(negedge clk);
        start = 1'b0;
        words = {32'($urandom), 32'($urandom), 32'($urandom)};
        finish_check(HELLO, "restart_ignored");
        repeat (20) @(negedge clk);
        check("restart_not_queued", 64'(busy), 64'(0));

        // Async reset mid-DATA of frame 2, then a clean retransmission.
        clear_rx();
        pulse_start(HELLO);
        repeat (FRAME + 18) @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_async_tx", 64'(tx), 64'(1));
        check("rst_async_busy", 64'(busy), 64'(0));
        check("rst_async_byte_count", 64'(byte_count), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME + 20) @(negedge clk);
        clear_rx();
        pulse_start(HELLO);
        finish_check(HELLO, "after_rst");

        // Random strings of random length.
        for (int it = 0; it < 6; it++) begin
            w = rand_string((it == 0) ? NB : int'($urandom_range(0, NB)));
            clear_rx();
            pulse_start(w);
            finish_check(w, $sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
